// File: rtl/bus_pkg.sv
// Shared backplane-bus definitions: frame layout, error codes, parser states and station address.
// RX_CHKSUM_EN selects the 139-byte frame that carries a trailing checksum byte.
package bus_pkg;

   localparam logic [10:0] OFS_DA   = 11'd0,
                           OFS_SA   = 11'd1,
                           OFS_FC   = 11'd2,
                           OFS_MODE = 11'd3,
                           OFS_ADDR = 11'd4,
                           OFS_TYPE = 11'd9,
                           OFS_DATA = 11'd10;
   localparam logic [10:0] DATA_LEN = 11'd128;

`ifdef RX_CHKSUM_EN
   localparam logic [10:0] FRM_LEN_DEF = 11'd139;
`else
   localparam logic [10:0] FRM_LEN_DEF = 11'd138;
`endif

   localparam logic [2:0] ERR_NONE   = 3'd0,
                          ERR_LEN    = 3'd1,
                          ERR_DA     = 3'd2,
                          ERR_SA     = 3'd3,
                          ERR_FC     = 3'd4,
                          ERR_TYPE   = 3'd5,
                          ERR_CHKSUM = 3'd6,
                          ERR_OVR    = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR, ST_CHK, ST_DATA, ST_DONE, ST_ERR
   } rx_state_t;

   typedef struct packed {
      logic [7:0]  da;
      logic [7:0]  sa;
      logic [7:0]  fc;
      logic [7:0]  mode;
      logic [23:0] addr;
      logic [7:0]  typ;
   } rx_hdr_t;

   // Station address from rack/slot; intentionally wraps modulo 256.
   function automatic logic [7:0] own_addr(input logic [2:0] rack, input logic [3:0] slot);
      return {5'd0, rack} * 8'd14 + 8'd14 - {4'd0, slot};
   endfunction

endpackage

// File: rtl/rx_rd_pipe.sv
// Delay line that tracks which buffer reads are in flight and the byte index each one carries.
module rx_rd_pipe #(
   parameter int RD_LAT = 2,
   parameter int IW     = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          vld_in,
   input  logic [IW-1:0] idx_in,
   output logic          vld_out,
   output logic [IW-1:0] idx_out
);

   logic [RD_LAT:1]         vld_pipe;
   logic [RD_LAT:1][IW-1:0] idx_pipe;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         vld_pipe <= '0;
         idx_pipe <= '0;
      end else begin
         vld_pipe[1] <= vld_in;
         idx_pipe[1] <= idx_in;
         for (int s = 2; s <= RD_LAT; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            idx_pipe[s] <= idx_pipe[s-1];
         end
      end
   end

   assign vld_out = vld_pipe[RD_LAT];
   assign idx_out = idx_pipe[RD_LAT];

endmodule

// File: rtl/rx_bus_parser.sv
// Backplane frame receiver: validates the header, streams the payload to staging RAM, reports MODE/ADDR.
// Optional RX_CHKSUM_EN: verify the trailing sum byte after the payload has been written.
module rx_bus_parser
   import bus_pkg::*;
#(
   parameter int          RD_LAT   = 2,
   parameter logic [7:0]  MST_ADDR = 8'hFE,
   parameter logic [7:0]  FC_CMD   = 8'h10,
   parameter logic [7:0]  TYPE_EXP = 8'h60,
   parameter logic [10:0] FRM_LEN  = FRM_LEN_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  rack_id,
   input  logic [3:0]  slot_id,
   input  logic        ini_done,
   input  logic        rx_done,
   input  logic [10:0] rx_data_len,
   output logic        rx_buf_rden,
   output logic [10:0] rx_buf_raddr,
   input  logic [7:0]  rx_buf_rdata,
   output logic        data_wren,
   output logic [6:0]  data_waddr,
   output logic [7:0]  data_wdata,
   output logic        rx_flag,
   output logic [7:0]  rx_mode,
   output logic [23:0] rx_addr,
   output logic        frame_err,
   output logic [2:0]  err_code
);

   rx_state_t   state, state_nxt;
   rx_hdr_t     hdr;
   logic        ini_d, own_vld, own_pend;
   logic [7:0]  own;
   logic [2:0]  pend_rack;
   logic [3:0]  pend_slot;
   logic        rd_act;
   logic [10:0] rd_cnt;
   logic        pv;
   logic [10:0] pidx;
   logic [2:0]  err_pend, chk_code, fail_code;
   logic        chk_pass, start, fail, data_end;

`ifdef RX_CHKSUM_EN
   logic [7:0]  sum;
   logic        chk_seen, chk_ok;
   assign data_end = chk_seen;
`else
   assign data_end = data_wren && (data_waddr == 7'd127);
`endif

   assign rx_buf_rden  = rd_act;
   assign rx_buf_raddr = rd_act ? rd_cnt : 11'd0;

   rx_rd_pipe #(.RD_LAT(RD_LAT), .IW(11)) u_rd_pipe (
      .clk     (clk),
      .reset   (reset),
      .flush   (state == ST_ERR),
      .vld_in  (rd_act),
      .idx_in  (rd_cnt),
      .vld_out (pv),
      .idx_out (pidx)
   );

   // Header check order sets the reported reason when several fields are wrong.
   always_comb begin
      chk_code = ERR_NONE;
      if (!(hdr.da == own || hdr.da == 8'hFF)) chk_code = ERR_DA;
      else if (hdr.sa != MST_ADDR)             chk_code = ERR_SA;
      else if (hdr.fc != FC_CMD)               chk_code = ERR_FC;
      else if (hdr.typ != TYPE_EXP)            chk_code = ERR_TYPE;
      chk_pass = (chk_code == ERR_NONE);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      fail      = 1'b0;
      fail_code = ERR_NONE;
      case (state)
         ST_IDLE:
            if (rx_done && own_vld) begin
               if (rx_data_len != FRM_LEN) begin
                  state_nxt = ST_ERR;
                  fail      = 1'b1;
                  fail_code = ERR_LEN;
               end else begin
                  state_nxt = ST_HDR;
                  start     = 1'b1;
               end
            end
         // Payload reads keep streaming while the last header bytes land, so no bubble.
         ST_HDR:
            if (pv && pidx == OFS_TYPE) state_nxt = ST_CHK;
         ST_CHK:
            if (chk_pass) state_nxt = ST_DATA;
            else begin
               state_nxt = ST_ERR;
               fail      = 1'b1;
               fail_code = chk_code;
            end
         ST_DATA:
            if (data_end) begin
`ifdef RX_CHKSUM_EN
               if (chk_ok) state_nxt = ST_DONE;
               else begin
                  state_nxt = ST_ERR;
                  fail      = 1'b1;
                  fail_code = ERR_CHKSUM;
               end
`else
               state_nxt = ST_DONE;
`endif
            end
         ST_DONE: state_nxt = ST_IDLE;
         ST_ERR:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ini_d      <= 1'b0;
         own_vld    <= 1'b0;
         own_pend   <= 1'b0;
         own        <= 8'd0;
         pend_rack  <= 3'd0;
         pend_slot  <= 4'd0;
         rd_act     <= 1'b0;
         rd_cnt     <= 11'd0;
         hdr        <= '0;
         err_pend   <= ERR_NONE;
         data_wren  <= 1'b0;
         data_waddr <= 7'd0;
         data_wdata <= 8'd0;
         rx_flag    <= 1'b0;
         rx_mode    <= 8'd0;
         rx_addr    <= 24'd0;
         frame_err  <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         ini_d <= ini_done;
         // A mid-frame address change is parked until the parser is idle again.
         if (ini_done && !ini_d) begin
            if (state == ST_IDLE) begin
               own      <= own_addr(rack_id, slot_id);
               own_vld  <= 1'b1;
               own_pend <= 1'b0;
            end else begin
               pend_rack <= rack_id;
               pend_slot <= slot_id;
               own_pend  <= 1'b1;
            end
         end else if (own_pend && state == ST_IDLE) begin
            own      <= own_addr(pend_rack, pend_slot);
            own_vld  <= 1'b1;
            own_pend <= 1'b0;
         end

         if (start) begin
            rd_act <= 1'b1;
            rd_cnt <= 11'd0;
         end else if (fail) begin
            rd_act <= 1'b0;
         end else if (rd_act) begin
            if (rd_cnt == FRM_LEN - 11'd1) rd_act <= 1'b0;
            rd_cnt <= rd_cnt + 11'd1;
         end

         if (pv && state == ST_HDR) begin
            case (pidx)
               OFS_DA:           hdr.da          <= rx_buf_rdata;
               OFS_SA:           hdr.sa          <= rx_buf_rdata;
               OFS_FC:           hdr.fc          <= rx_buf_rdata;
               OFS_MODE:         hdr.mode        <= rx_buf_rdata;
               OFS_ADDR:         hdr.addr[23:16] <= rx_buf_rdata;
               OFS_ADDR + 11'd1: hdr.addr[15:8]  <= rx_buf_rdata;
               OFS_ADDR + 11'd2: hdr.addr[7:0]   <= rx_buf_rdata;
               OFS_TYPE:         hdr.typ         <= rx_buf_rdata;
               default: ;
            endcase
         end

         data_wren <= 1'b0;
         if (pv && pidx >= OFS_DATA && pidx < OFS_DATA + DATA_LEN &&
             (state == ST_DATA || (state == ST_CHK && chk_pass))) begin
            data_wren  <= 1'b1;
            data_waddr <= 7'(pidx - OFS_DATA);
            data_wdata <= rx_buf_rdata;
         end

         rx_flag   <= 1'b0;
         frame_err <= 1'b0;
         if (fail) err_pend <= fail_code;
         if (state == ST_DONE) begin
            rx_flag <= 1'b1;
            rx_mode <= hdr.mode;
            rx_addr <= hdr.addr;
         end
         if (state == ST_ERR) begin
            frame_err <= 1'b1;
            err_code  <= err_pend;
         end
         if (rx_done && state != ST_IDLE) begin
            frame_err <= 1'b1;
            err_code  <= ERR_OVR;
         end
      end
   end

`ifdef RX_CHKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sum      <= 8'd0;
         chk_seen <= 1'b0;
         chk_ok   <= 1'b0;
      end else if (start) begin
         sum      <= 8'd0;
         chk_seen <= 1'b0;
         chk_ok   <= 1'b0;
      end else if (pv && (state == ST_HDR || state == ST_CHK || state == ST_DATA)) begin
         if (pidx < FRM_LEN - 11'd1) sum <= sum + rx_buf_rdata;
         else begin
            chk_seen <= 1'b1;
            chk_ok   <= (sum == rx_buf_rdata);
         end
      end
   end
`endif

endmodule
